multicycle_control: RTL and testbench

Multicycle MIPS control unit: the FSM that produces the 3-bit ALU function code and all datapath enables, one instruction at a time. It is the driving end of the 32-bit ALU's `ctl`/`zero` interface. It decodes `opcode`/`funct` from the instruction register and sequences fetch, decode, execute, memory and write-back. It stalls on a memory-ready handshake and folds the ALU `zero` flag into the PC write enable for `beq`.

---
 rtl/multicycle_control_if.sv | 65 ++++++
 rtl/multicycle_control.sv | 207 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control-unit bus between the multicycle control FSM and the MIPS datapath.
// The master is the control unit: it consumes instruction fields and status
// and drives every datapath enable and the ALU function code.
interface multicycle_control_if;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic [2:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;

    modport master (
        input  opcode,
        input  funct,
        input  zero,
        input  mem_ready,
        output alu_ctl,
        output alu_src_a,
        output alu_src_b,
        output pc_source,
        output pc_en,
        output i_or_d,
        output mem_read,
        output mem_write,
        output ir_write,
        output reg_write,
        output reg_dst,
        output mem_to_reg,
        output illegal_op
    );

    modport slave (
        output opcode,
        output funct,
        output zero,
        output mem_ready,
        input  alu_ctl,
        input  alu_src_a,
        input  alu_src_b,
        input  pc_source,
        input  pc_en,
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        input  ir_write,
        input  reg_write,
        input  reg_dst,
        input  mem_to_reg,
        input  illegal_op
    );

endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/write-back
// one instruction at a time, stalls on the memory-ready handshake and folds the
// ALU zero flag into the PC write enable for beq. Outputs are a Moore decode of
// the state, qualified by mem_ready (FETCH) and zero (BRANCH) in the same cycle.
module multicycle_control (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALU_W   = 3;

    localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
    localparam logic [STATE_W-1:0] S_EXEC   = 4'd6;
    localparam logic [STATE_W-1:0] S_RCOMP  = 4'd7;
    localparam logic [STATE_W-1:0] S_BRANCH = 4'd8;
    localparam logic [STATE_W-1:0] S_JUMP   = 4'd9;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;

    logic               funct_ok_c;
    logic [ALU_W-1:0]   funct_ctl_c;

    logic [ALU_W-1:0]   alu_ctl_c;
    logic               alu_src_a_c;
    logic [1:0]         alu_src_b_c;
    logic [1:0]         pc_source_c;
    logic               pc_en_c;
    logic               i_or_d_c;
    logic               mem_read_c;
    logic               mem_write_c;
    logic               ir_write_c;
    logic               reg_write_c;
    logic               reg_dst_c;
    logic               mem_to_reg_c;
    logic               illegal_op_c;

    // Map an R-type funct field onto the ALU function code; flag unsupported ones
    always_comb begin
        funct_ok_c  = 1'b1;
        funct_ctl_c = ALU_ADD;
        case (bus.funct)
            FN_ADD:  funct_ctl_c = ALU_ADD;
            FN_SUB:  funct_ctl_c = ALU_SUB;
            FN_AND:  funct_ctl_c = ALU_AND;
            FN_OR:   funct_ctl_c = ALU_OR;
            FN_SLT:  funct_ctl_c = ALU_SLT;
            default: funct_ok_c  = 1'b0;
        endcase
    end

    // State register; reset abandons any instruction in flight and returns to fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d      = S_FETCH;
        alu_ctl_c    = ALU_ADD;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRC_B_REG;
        pc_source_c  = PC_ALU;
        pc_en_c      = 1'b0;
        i_or_d_c     = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        illegal_op_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 computed alongside the fetch; both commit when memory completes
                mem_read_c  = 1'b1;
                alu_src_b_c = SRC_B_FOUR;
                ir_write_c  = bus.mem_ready;
                pc_en_c     = bus.mem_ready;
                state_d     = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut
                alu_src_b_c = SRC_B_IMMSH;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegal_op_c = 1'b1;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRC_B_IMM;
                state_d     = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read_c = 1'b1;
                i_or_d_c   = 1'b1;
                state_d    = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                mem_write_c = 1'b1;
                i_or_d_c    = 1'b1;
                state_d     = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRC_B_REG;
                if (funct_ok_c) begin
                    alu_ctl_c = funct_ctl_c;
                    state_d   = S_RCOMP;
                end else begin
                    illegal_op_c = 1'b1;
                    state_d      = S_FETCH;
                end
            end
            S_RCOMP: begin
                reg_write_c = 1'b1;
                reg_dst_c   = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                // Compare A-B; take the precomputed target only when equal
                alu_src_a_c = 1'b1;
                alu_src_b_c = SRC_B_REG;
                alu_ctl_c   = ALU_SUB;
                pc_source_c = PC_ALUOUT;
                pc_en_c     = bus.zero;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_source_c = PC_JUMP;
                pc_en_c     = 1'b1;
                state_d     = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // While reset is held the FETCH request is visible but nothing may commit
    assign bus.alu_ctl    = alu_ctl_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.pc_source  = pc_source_c;
    assign bus.i_or_d     = i_or_d_c;
    assign bus.mem_read   = mem_read_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.pc_en      = pc_en_c      & ~reset;
    assign bus.mem_write  = mem_write_c  & ~reset;
    assign bus.ir_write   = ir_write_c   & ~reset;
    assign bus.reg_write  = reg_write_c  & ~reset;
    assign bus.illegal_op = illegal_op_c & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded random test of the multicycle control unit. The driver expands
// each instruction into its per-cycle expected outputs from the instruction's
// phase sequence; a negedge monitor compares every cycle against the queue.
module tb_multicycle_control;

    typedef struct packed {
        logic [2:0] alu_ctl;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       pc_en;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal_op;
    } out_t;

    typedef struct {
        out_t  e;
        string name;
    } sb_t;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_J = 4, K_ILL = 5;

    logic clk;
    logic reset;
    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    sb_t        sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end (got timeout, required finish)");
        $fatal(1, "watchdog");
    end

    // ---------------- expected-output builders (from the phase tables) -----
    function automatic out_t base();
        out_t o = '0;
        o.alu_ctl = 3'b010;
        return o;
    endfunction

    function automatic out_t e_fetch(input logic done);
        out_t o = base();
        o.mem_read = 1'b1; o.alu_src_b = 2'b01;
        o.ir_write = done; o.pc_en = done;
        return o;
    endfunction

    function automatic out_t e_decode(input logic ill);
        out_t o = base();
        o.alu_src_b = 2'b11; o.illegal_op = ill;
        return o;
    endfunction

    function automatic out_t e_memadr();
        out_t o = base();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
        return o;
    endfunction

    function automatic out_t e_memrd();
        out_t o = base();
        o.mem_read = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction

    function automatic out_t e_memwb();
        out_t o = base();
        o.reg_write = 1'b1; o.mem_to_reg = 1'b1;
        return o;
    endfunction

    function automatic out_t e_memwr();
        out_t o = base();
        o.mem_write = 1'b1; o.i_or_d = 1'b1;
        return o;
    endfunction

    // R-type ALU code table; returns legal flag via output
    function automatic out_t e_exec(input logic [5:0] fn, output logic legal);
        out_t o = base();
        o.alu_src_a = 1'b1; o.alu_src_b = 2'b00;
        legal = 1'b1;
        case (fn)
            6'b100000: o.alu_ctl = 3'b010;
            6'b100010: o.alu_ctl = 3'b110;
            6'b100100: o.alu_ctl = 3'b000;
            6'b100101: o.alu_ctl = 3'b001;
            6'b101010: o.alu_ctl = 3'b111;
            default: begin legal = 1'b0; o.illegal_op = 1'b1; end
        endcase
        return o;
    endfunction

    function automatic out_t e_rcomp();
        out_t o = base();
        o.reg_write = 1'b1; o.reg_dst = 1'b1;
        return o;
    endfunction

    function automatic out_t e_branch(input logic z);
        out_t o = base();
        o.alu_src_a = 1'b1; o.alu_ctl = 3'b110; o.pc_source = 2'b01; o.pc_en = z;
        return o;
    endfunction

    function automatic out_t e_jump();
        out_t o = base();
        o.pc_source = 2'b10; o.pc_en = 1'b1;
        return o;
    endfunction

    // ---------------- driver ----------------------------------------------
    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: apply inputs just after the edge and queue the expectation
    task automatic do_cycle(input logic mr, input logic z, input logic rst,
                            input out_t e, input string name);
        sb_t it;
        @(posedge clk);
        #1;
        reset         = rst;
        bus.opcode    = cur_op;
        bus.funct     = cur_fn;
        bus.mem_ready = mr;
        bus.zero      = z;
        it.e = e;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic fetch_phase(input int stalls);
        for (int i = 0; i < stalls; i++) do_cycle(1'b0, rbit(), 1'b0, e_fetch(1'b0), "fetch_wait");
        do_cycle(1'b1, rbit(), 1'b0, e_fetch(1'b1), "fetch_done");
    endtask

    task automatic run_instr(input int kind, input logic [5:0] fn, input int fs,
                             input int ms, input logic zb);
        logic legal;
        out_t ex;
        case (kind)
            K_LW:  cur_op = 6'b100011;
            K_SW:  cur_op = 6'b101011;
            K_R:   cur_op = 6'b000000;
            K_BEQ: cur_op = 6'b000100;
            K_J:   cur_op = 6'b000010;
            default: begin
                cur_op = fn;
                while (cur_op == 6'b100011 || cur_op == 6'b101011 || cur_op == 6'b000000 ||
                       cur_op == 6'b000100 || cur_op == 6'b000010)
                    cur_op = 6'($urandom);
            end
        endcase
        cur_fn = fn;
        fetch_phase(fs);
        if (kind == K_ILL) begin
            do_cycle(rbit(), rbit(), 1'b0, e_decode(1'b1), "decode_illegal");
            return;
        end
        do_cycle(rbit(), rbit(), 1'b0, e_decode(1'b0), "decode");
        case (kind)
            K_LW: begin
                do_cycle(rbit(), rbit(), 1'b0, e_memadr(), "lw_memadr");
                for (int i = 0; i < ms; i++) do_cycle(1'b0, rbit(), 1'b0, e_memrd(), "lw_memrd_wait");
                do_cycle(1'b1, rbit(), 1'b0, e_memrd(), "lw_memrd_done");
                do_cycle(rbit(), rbit(), 1'b0, e_memwb(), "lw_memwb");
            end
            K_SW: begin
                do_cycle(rbit(), rbit(), 1'b0, e_memadr(), "sw_memadr");
                for (int i = 0; i < ms; i++) do_cycle(1'b0, rbit(), 1'b0, e_memwr(), "sw_memwr_wait");
                do_cycle(1'b1, rbit(), 1'b0, e_memwr(), "sw_memwr_done");
            end
            K_R: begin
                ex = e_exec(fn, legal);
                do_cycle(rbit(), rbit(), 1'b0, ex, legal ? "r_exec" : "r_exec_illegal");
                if (legal) do_cycle(rbit(), rbit(), 1'b0, e_rcomp(), "r_rcomp");
            end
            K_BEQ: do_cycle(rbit(), zb, 1'b0, e_branch(zb), "beq_branch");
            default: do_cycle(rbit(), rbit(), 1'b0, e_jump(), "j_jump");
        endcase
    endtask

    // ---------------- monitor ---------------------------------------------
    // Compare live outputs with the oldest queued expectation each cycle
    always @(negedge clk) begin
        sb_t  it;
        out_t act;
        if (sb.size() > 0) begin
            it  = sb.pop_front();
            act = {bus.alu_ctl, bus.alu_src_a, bus.alu_src_b, bus.pc_source, bus.pc_en,
                   bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write,
                   bus.reg_dst, bus.mem_to_reg, bus.illegal_op};
            checks++;
            if (act !== it.e) begin
                errors++;
                $display("FAIL %s @%0t: got %h required %h", it.name, $time, act, it.e);
            end
        end
    end

    // ---------------- stimulus --------------------------------------------
    logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] fn;
        int         kind;
        reset         = 1'b1;
        bus.opcode    = 6'd0;
        bus.funct     = 6'd0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;

        // Reset held: fetch request visible, commits suppressed even with mem_ready
        for (int i = 0; i < 3; i++) do_cycle(1'b1, rbit(), 1'b1, e_fetch(1'b0), "reset_hold");

        run_instr(K_LW, 6'd0, 0, 0, 1'b0);
        run_instr(K_LW, 6'd0, 0, 3, 1'b0);
        run_instr(K_SW, 6'd0, 0, 0, 1'b0);
        for (int i = 0; i < 5; i++) run_instr(K_R, rfn[i], 0, 0, 1'b0);
        run_instr(K_BEQ, 6'd0, 0, 0, 1'b1);
        run_instr(K_BEQ, 6'd0, 0, 0, 1'b0);
        run_instr(K_J, 6'd0, 0, 0, 1'b0);
        run_instr(K_ILL, 6'b111111, 0, 0, 1'b0);
        run_instr(K_R, 6'b000111, 0, 0, 1'b0);

        // sw abandoned by reset while waiting in the write phase
        cur_op = 6'b101011;
        fetch_phase(0);
        do_cycle(rbit(), rbit(), 1'b0, e_decode(1'b0), "decode");
        do_cycle(rbit(), rbit(), 1'b0, e_memadr(), "sw_memadr");
        do_cycle(1'b0, rbit(), 1'b0, e_memwr(), "sw_memwr_wait");
        do_cycle(1'b0, rbit(), 1'b0, e_memwr(), "sw_memwr_wait");
        do_cycle(1'b1, rbit(), 1'b1, e_fetch(1'b0), "reset_mid_sw");
        do_cycle(1'b1, rbit(), 1'b1, e_fetch(1'b0), "reset_mid_sw");
        run_instr(K_LW, 6'd0, 2, 1, 1'b0);

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 5);
            if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
            else fn = rfn[$urandom_range(0, 4)];
            run_instr(kind, fn, $urandom_range(0, 3), $urandom_range(0, 3), rbit());
        end

        repeat (2) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
